// File: rtl/mem_arbiter_if.sv
// ---------------------------------------------------------------------------
// mem_arbiter_if
//   Bundles the two requester ports and the exmem-side bus of mem_arbiter.
//   Port N (N = 0 cpu, 1 loader/DMA):
//     reqN, weN, adrN, wdataN  requester -> arbiter
//     ackN, rdataN             arbiter   -> requester
//   Memory side:
//     mem_read, mem_write, mem_adr, mem_wdata  arbiter -> exmem
//     mem_rdata                                exmem   -> arbiter
//   busy: arbiter status, high outside IDLE.
//   slave  : the arbiter's view.
//   master : the surrounding system's view (requesters plus exmem).
// ---------------------------------------------------------------------------
interface mem_arbiter_if #(
    parameter int WIDTH = 8
);
    logic             req0, we0, ack0;
    logic [WIDTH-1:0] adr0, wdata0, rdata0;
    logic             req1, we1, ack1;
    logic [WIDTH-1:0] adr1, wdata1, rdata1;
    logic             mem_read, mem_write;
    logic [WIDTH-1:0] mem_adr, mem_wdata, mem_rdata;
    logic             busy;

    modport slave (
        input  req0, we0, adr0, wdata0,
        input  req1, we1, adr1, wdata1,
        output ack0, rdata0, ack1, rdata1,
        output mem_read, mem_write, mem_adr, mem_wdata,
        input  mem_rdata,
        output busy
    );

    modport master (
        output req0, we0, adr0, wdata0,
        output req1, we1, adr1, wdata1,
        input  ack0, rdata0, ack1, rdata1,
        input  mem_read, mem_write, mem_adr, mem_wdata,
        output mem_rdata,
        input  busy
    );
endinterface

// File: rtl/mem_arbiter.sv
// ---------------------------------------------------------------------------
// mem_arbiter
//   Two-port round-robin arbiter in front of the single exmem memory.
//   One access at a time: IDLE -> ACCESS -> WAIT (MEM_LAT cycles) -> DONE.
//   Strobes are driven for the single ACCESS cycle; read data is captured on
//   the last WAIT cycle and the winner gets a one-cycle ack in DONE.
// Parameters
//   WIDTH    data/address width
//   MEM_LAT  strobe-to-valid-mem_rdata latency, 1..15
// Ports
//   clk    system clock, posedge
//   reset  asynchronous, active-high
//   bus    mem_arbiter_if.slave (requester ports, exmem bus, busy)
// ---------------------------------------------------------------------------
module mem_arbiter #(
    parameter int WIDTH   = 8,
    parameter int MEM_LAT = 1
) (
    input  logic                clk,
    input  logic                reset,
    mem_arbiter_if.slave        bus
);
    localparam int NUM_PORTS = 2;
    localparam int CW        = 4;

    typedef enum logic [1:0] {IDLE, ACCESS, WAIT, DONE} state_t;

    state_t state, state_d;

    // Port signals gathered into packed arrays so per-port logic is indexed.
    logic [NUM_PORTS-1:0]            req;
    logic [NUM_PORTS-1:0]            we;
    logic [NUM_PORTS-1:0][WIDTH-1:0] adr, wdata;
    logic [NUM_PORTS-1:0]            ack;

    logic [WIDTH-1:0] rdata_q [NUM_PORTS];

    logic             last;      // port granted most recently
    logic             win;       // port owning the current transaction
    logic             win_d;
    logic             we_q;
    logic [WIDTH-1:0] adr_q, wdata_q;
    logic [CW-1:0]    cnt;

    assign req   = {bus.req1, bus.req0};
    assign we    = {bus.we1, bus.we0};
    assign adr   = {bus.adr1, bus.adr0};
    assign wdata = {bus.wdata1, bus.wdata0};

    // With both requesting, the port that did not go last wins; otherwise
    // the single requester wins (req[1] picks port 1 when only it is set).
    assign win_d = (req == 2'b11) ? ~last : req[1];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_d;
    end

    always_comb begin
        state_d   = state;
        ack       = '0;
        bus.mem_read  = 1'b0;
        bus.mem_write = 1'b0;
        case (state)
            IDLE:   if (|req) state_d = ACCESS;
            ACCESS: begin
                bus.mem_read  = ~we_q;
                bus.mem_write = we_q;
                state_d       = WAIT;
            end
            WAIT:   if (cnt == CW'(1)) state_d = DONE;
            DONE: begin
                ack[win] = 1'b1;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Request latch and wait counter. Inputs are only looked at in IDLE, so
    // requesters may change adr/we/wdata freely once granted.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last    <= 1'b1;
            win     <= 1'b0;
            we_q    <= 1'b0;
            adr_q   <= '0;
            wdata_q <= '0;
            cnt     <= '0;
        end else begin
            case (state)
                IDLE: if (|req) begin
                    win     <= win_d;
                    last    <= win_d;
                    we_q    <= we[win_d];
                    adr_q   <= adr[win_d];
                    wdata_q <= wdata[win_d];
                end
                ACCESS: cnt <= CW'(MEM_LAT);
                WAIT:   cnt <= cnt - CW'(1);
                default: ;
            endcase
        end
    end

    // Per-port read data: loaded on the last WAIT cycle of a read owned by
    // that port, otherwise held.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_PORTS; i++) rdata_q[i] <= '0;
        end else begin
            for (int i = 0; i < NUM_PORTS; i++)
                if (state == WAIT && cnt == CW'(1) && !we_q && win == 1'(i))
                    rdata_q[i] <= bus.mem_rdata;
        end
    end

    assign bus.ack0      = ack[0];
    assign bus.ack1      = ack[1];
    assign bus.rdata0    = rdata_q[0];
    assign bus.rdata1    = rdata_q[1];
    assign bus.mem_adr   = adr_q;
    assign bus.mem_wdata = wdata_q;
    assign bus.busy      = (state != IDLE);
endmodule

// File: tb/tb_mem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_arbiter
//   Directed bench for mem_arbiter. dut uses MEM_LAT=1 with a behavioural
//   exmem (initial contents adr ^ 8'h5A, one-cycle read register); dut3 uses
//   MEM_LAT=3 with mem_rdata driven cycle by cycle from the stimulus.
//   Cycle k below means the interval after the k-th rising edge; outputs are
//   sampled 1 ns after the edge.
// ---------------------------------------------------------------------------
module tb_mem_arbiter;
    logic clk;
    logic reset;
    int   checks = 0;
    int   fails  = 0;

    mem_arbiter_if #(.WIDTH(8)) bus ();
    mem_arbiter_if #(.WIDTH(8)) bus3 ();

    mem_arbiter #(.WIDTH(8), .MEM_LAT(1)) dut  (.clk(clk), .reset(reset), .bus(bus));
    mem_arbiter #(.WIDTH(8), .MEM_LAT(3)) dut3 (.clk(clk), .reset(reset), .bus(bus3));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // exmem model: unwritten locations read as adr ^ 8'h5A.
    bit   [255:0] wr_valid;
    logic [7:0]   wr_data [256];

    always @(posedge clk) begin
        if (bus.mem_write) begin
            wr_valid[bus.mem_adr] <= 1'b1;
            wr_data[bus.mem_adr]  <= bus.mem_wdata;
        end
        if (bus.mem_read)
            bus.mem_rdata <= wr_valid[bus.mem_adr] ? wr_data[bus.mem_adr]
                                                   : (bus.mem_adr ^ 8'h5A);
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        bus.req0 = 1'b1; bus.we0 = 1'b0; bus.adr0 = 8'h10;
        repeat (2) tick;
        checks++; if (bus.ack0 !== 1'b0 || bus.ack1 !== 1'b0) begin fails++; $display("FAIL reset_ack: got %b%b want 00", bus.ack1, bus.ack0); end
        checks++; if (bus.mem_read !== 1'b0 || bus.mem_write !== 1'b0) begin fails++; $display("FAIL reset_strobe: got r=%b w=%b want 0", bus.mem_read, bus.mem_write); end
        checks++; if (bus.mem_adr !== 8'h00 || bus.mem_wdata !== 8'h00) begin fails++; $display("FAIL reset_bus: got adr=%h wd=%h want 00", bus.mem_adr, bus.mem_wdata); end
        checks++; if (bus.rdata0 !== 8'h00 || bus.rdata1 !== 8'h00 || bus.busy !== 1'b0) begin fails++; $display("FAIL reset_misc: got rd0=%h rd1=%h busy=%b want 0", bus.rdata0, bus.rdata1, bus.busy); end
        reset = 1'b0;
        tick;
        checks++; if (bus.mem_read !== 1'b1 || bus.mem_adr !== 8'h10) begin fails++; $display("FAIL first_strobe: got r=%b adr=%h want 1 10", bus.mem_read, bus.mem_adr); end
        tick;
        checks++; if (bus.mem_read !== 1'b0) begin fails++; $display("FAIL strobe_len: got %b want 0", bus.mem_read); end
        tick;
        checks++; if (bus.ack0 !== 1'b1 || bus.rdata0 !== 8'h4A) begin fails++; $display("FAIL first_ack: got ack=%b rd=%h want 1 4a", bus.ack0, bus.rdata0); end
        bus.req0 = 1'b0;
        tick;
        checks++; if (bus.ack0 !== 1'b0 || bus.busy !== 1'b0) begin fails++; $display("FAIL ack_pulse: got ack=%b busy=%b want 0 0", bus.ack0, bus.busy); end
    endtask

    task automatic test_write;
        bus.req1 = 1'b1; bus.we1 = 1'b1; bus.adr1 = 8'h20; bus.wdata1 = 8'hA5;
        tick;
        checks++; if (bus.mem_write !== 1'b1 || bus.mem_read !== 1'b0) begin fails++; $display("FAIL wr_strobe: got w=%b r=%b want 1 0", bus.mem_write, bus.mem_read); end
        checks++; if (bus.mem_adr !== 8'h20 || bus.mem_wdata !== 8'hA5) begin fails++; $display("FAIL wr_bus: got adr=%h wd=%h want 20 a5", bus.mem_adr, bus.mem_wdata); end
        tick;
        checks++; if (bus.mem_write !== 1'b0 || bus.mem_wdata !== 8'hA5) begin fails++; $display("FAIL wr_len: got w=%b wd=%h want 0 a5", bus.mem_write, bus.mem_wdata); end
        tick;
        checks++; if (bus.ack1 !== 1'b1 || bus.ack0 !== 1'b0) begin fails++; $display("FAIL wr_ack: got ack1=%b ack0=%b want 1 0", bus.ack1, bus.ack0); end
        bus.req1 = 1'b0; bus.we1 = 1'b0;
        tick;
        bus.req0 = 1'b1; bus.we0 = 1'b0; bus.adr0 = 8'h20;
        repeat (3) tick;
        checks++; if (bus.ack0 !== 1'b1 || bus.rdata0 !== 8'hA5) begin fails++; $display("FAIL readback: got ack=%b rd=%h want 1 a5", bus.ack0, bus.rdata0); end
        checks++; if (bus.rdata1 !== 8'h00) begin fails++; $display("FAIL wr_rdata1: got %h want 00", bus.rdata1); end
        bus.req0 = 1'b0;
        tick;
    endtask

    task automatic test_round_robin;
        reset = 1'b1;
        tick;
        bus.req0 = 1'b1; bus.we0 = 1'b0; bus.adr0 = 8'h14;
        bus.req1 = 1'b1; bus.we1 = 1'b0; bus.adr1 = 8'h30;
        reset = 1'b0;
        for (int c = 1; c <= 16; c++) begin
            tick;
            checks++; if (bus.ack0 !== 1'((c == 3) || (c == 11))) begin fails++; $display("FAIL rr_ack0 c%0d: got %b", c, bus.ack0); end
            checks++; if (bus.ack1 !== 1'((c == 7) || (c == 15))) begin fails++; $display("FAIL rr_ack1 c%0d: got %b", c, bus.ack1); end
            checks++; if ((bus.ack0 & bus.ack1) !== 1'b0 || (bus.mem_read & bus.mem_write) !== 1'b0) begin fails++; $display("FAIL rr_excl c%0d: acks=%b%b strobes=%b%b", c, bus.ack1, bus.ack0, bus.mem_read, bus.mem_write); end
            if (c == 15) begin bus.req0 = 1'b0; bus.req1 = 1'b0; end
        end
        checks++; if (bus.rdata0 !== 8'h4E || bus.rdata1 !== 8'h6A) begin fails++; $display("FAIL rr_data: got %h %h want 4e 6a", bus.rdata0, bus.rdata1); end
    endtask

    task automatic test_ignore_changes;
        bus.req0 = 1'b1; bus.we0 = 1'b0; bus.adr0 = 8'h10;
        tick;
        checks++; if (bus.mem_read !== 1'b1 || bus.mem_adr !== 8'h10) begin fails++; $display("FAIL ig_strobe: got r=%b adr=%h want 1 10", bus.mem_read, bus.mem_adr); end
        bus.req0 = 1'b0;
        tick;
        bus.adr0 = 8'h30;
        #1;
        checks++; if (bus.mem_adr !== 8'h10) begin fails++; $display("FAIL ig_adr: got %h want 10", bus.mem_adr); end
        tick;
        checks++; if (bus.ack0 !== 1'b1 || bus.rdata0 !== 8'h4A) begin fails++; $display("FAIL ig_ack: got ack=%b rd=%h want 1 4a", bus.ack0, bus.rdata0); end
        tick;
        checks++; if (bus.ack0 !== 1'b0 || bus.busy !== 1'b0) begin fails++; $display("FAIL ig_idle: got ack=%b busy=%b want 0 0", bus.ack0, bus.busy); end
    endtask

    task automatic test_reset_abort;
        bus.req0 = 1'b1; bus.we0 = 1'b1; bus.adr0 = 8'h40; bus.wdata0 = 8'h77;
        tick;
        checks++; if (bus.mem_write !== 1'b1) begin fails++; $display("FAIL ab_strobe: got %b want 1", bus.mem_write); end
        bus.req0 = 1'b0;
        #2 reset = 1'b1;
        #1;
        checks++; if (bus.mem_write !== 1'b0 || bus.busy !== 1'b0 || bus.mem_adr !== 8'h00) begin fails++; $display("FAIL ab_async: got w=%b busy=%b adr=%h want 0 0 00", bus.mem_write, bus.busy, bus.mem_adr); end
        tick;
        reset = 1'b0; bus.we0 = 1'b0;
        for (int c = 1; c <= 4; c++) begin
            tick;
            checks++; if (bus.ack0 !== 1'b0 || bus.ack1 !== 1'b0) begin fails++; $display("FAIL ab_noack c%0d: got %b%b want 00", c, bus.ack1, bus.ack0); end
        end
        bus.req0 = 1'b1; bus.adr0 = 8'h40;
        bus.req1 = 1'b1; bus.we1 = 1'b0; bus.adr1 = 8'h41;
        tick;
        checks++; if (bus.mem_adr !== 8'h40) begin fails++; $display("FAIL ab_last: got adr %h want 40", bus.mem_adr); end
        repeat (2) tick;
        checks++; if (bus.ack0 !== 1'b1 || bus.ack1 !== 1'b0 || bus.rdata0 !== 8'h1A) begin fails++; $display("FAIL ab_read: got ack=%b%b rd=%h want 01 1a", bus.ack1, bus.ack0, bus.rdata0); end
        bus.req0 = 1'b0; bus.req1 = 1'b0;
        tick;
        checks++; if (bus.busy !== 1'b0) begin fails++; $display("FAIL ab_idle: got busy=%b want 0", bus.busy); end
    endtask

    task automatic test_latency3;
        bus3.req0 = 1'b1; bus3.we0 = 1'b0; bus3.adr0 = 8'h55; bus3.mem_rdata = 8'h00;
        tick;
        checks++; if (bus3.mem_read !== 1'b1 || bus3.mem_adr !== 8'h55) begin fails++; $display("FAIL l3_strobe: got r=%b adr=%h want 1 55", bus3.mem_read, bus3.mem_adr); end
        bus3.mem_rdata = 8'h11;
        for (int c = 2; c <= 4; c++) begin
            tick;
            checks++; if (bus3.ack0 !== 1'b0 || bus3.mem_read !== 1'b0) begin fails++; $display("FAIL l3_early c%0d: got ack=%b r=%b want 0 0", c, bus3.ack0, bus3.mem_read); end
            bus3.mem_rdata = 8'(c * 8'h11);
        end
        tick;
        checks++; if (bus3.ack0 !== 1'b1 || bus3.rdata0 !== 8'h44) begin fails++; $display("FAIL l3_ack: got ack=%b rd=%h want 1 44", bus3.ack0, bus3.rdata0); end
        bus3.req0 = 1'b0; bus3.mem_rdata = 8'h55;
        tick;
        checks++; if (bus3.ack0 !== 1'b0 || bus3.rdata0 !== 8'h44 || bus3.busy !== 1'b0) begin fails++; $display("FAIL l3_hold: got ack=%b rd=%h busy=%b want 0 44 0", bus3.ack0, bus3.rdata0, bus3.busy); end
    endtask

    initial begin
        reset = 1'b1;
        bus.req0 = 1'b0; bus.we0 = 1'b0; bus.adr0 = '0; bus.wdata0 = '0;
        bus.req1 = 1'b0; bus.we1 = 1'b0; bus.adr1 = '0; bus.wdata1 = '0;
        bus3.req0 = 1'b0; bus3.we0 = 1'b0; bus3.adr0 = '0; bus3.wdata0 = '0;
        bus3.req1 = 1'b0; bus3.we1 = 1'b0; bus3.adr1 = '0; bus3.wdata1 = '0;
        bus3.mem_rdata = '0;
        test_reset;
        test_write;
        test_round_robin;
        test_ignore_changes;
        test_reset_abort;
        test_latency3;
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
